// File: rtl/ber_pattern_gen.sv
// Reference FIFO: registered occupancy, so a pop only sees entries pushed on earlier edges.
// Pop data is the head entry (combinational); pushes while full and pops while empty are dropped.
module ber_ref_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_vld,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop_vld,
  output logic [W-1:0]             pop_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_vld && (count != FULL);
  assign do_pop  = pop_vld && (count != '0);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// BER test-word generator: one-cycle load latency, tx word held while tx_ready is low,
// loads stall when the reference FIFO plus the in-flight word would exceed its depth.
module ber_pattern_gen #(
  parameter int          WIDTH      = 12,
  parameter logic [14:0] SEED       = 15'h7FFF,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] fixed_word,
  input  logic [15:0]      inject_period,
  output logic [WIDTH-1:0] tx_word,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic             rx_valid,
  output logic [WIDTH-1:0] ref_word,
  output logic             ref_valid,
  output logic [31:0]      words_sent,
  output logic [31:0]      injected,
  output logic             underflow
);
  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [14:0] LFSR_INIT = (SEED == 15'd0) ? 15'h0001 : SEED;
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    MODE_PRBS  = 2'b00,
    MODE_INCR  = 2'b01,
    MODE_FIXED = 2'b10,
    MODE_ALT   = 2'b11
  } mode_e;

  logic [14:0]      lfsr;
  logic [14:0]      lfsr_nxt;
  logic [WIDTH-1:0] count_word;
  logic             alt_phase;
  logic [15:0]      inj_cnt;
  logic             tx_corrupt;
  logic [WIDTH-1:0] prbs_word;
  logic [WIDTH-1:0] alt_word;
  logic [WIDTH-1:0] gen_word;
  logic             inj_hit;
  logic             xfer;
  logic             load;
  logic [AW:0]      fifo_count;
  logic [WIDTH-1:0] fifo_head;
  logic [AW+1:0]    pending;

  always_comb begin
    lfsr_nxt  = lfsr;
    prbs_word = '0;
    alt_word  = '0;
    // Serial LFSR unrolled WIDTH steps; the first bit out lands in the MSB.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      prbs_word[i] = lfsr_nxt[14] ^ lfsr_nxt[13];
      lfsr_nxt     = {lfsr_nxt[13:0], prbs_word[i]};
    end
    for (int i = 0; i < WIDTH; i++) begin
      alt_word[i] = ((i % 2) == 0) ^ alt_phase;
    end
    case (mode_e'(mode))
      MODE_PRBS:  gen_word = prbs_word;
      MODE_INCR:  gen_word = count_word;
      MODE_FIXED: gen_word = fixed_word;
      default:    gen_word = alt_word;
    endcase
  end

  assign inj_hit = (inject_period != 16'd0) && (inj_cnt == inject_period - 16'd1);
  assign xfer    = tx_valid && tx_ready;
  // The presented word already owns a FIFO slot, so it counts against the depth.
  assign pending = {1'b0, fifo_count} + {{(AW+1){1'b0}}, tx_valid};
  assign load    = enable && (pending < DEPTH_W) && (!tx_valid || xfer);

  ber_ref_fifo #(
    .W     (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_ref_fifo (
    .clock    (clock),
    .reset    (reset),
    .push_vld (xfer),
    .push_dat (tx_word ^ WIDTH'(tx_corrupt)),
    .pop_vld  (rx_valid),
    .pop_dat  (fifo_head),
    .count    (fifo_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_word    <= '0;
      tx_valid   <= 1'b0;
      tx_corrupt <= 1'b0;
      lfsr       <= LFSR_INIT;
      count_word <= '0;
      alt_phase  <= 1'b0;
      inj_cnt    <= '0;
      ref_word   <= '0;
      ref_valid  <= 1'b0;
      words_sent <= '0;
      injected   <= '0;
      underflow  <= 1'b0;
    end else begin
      if (xfer) begin
        words_sent <= words_sent + 32'd1;
        if (tx_corrupt) injected <= injected + 32'd1;
      end
      if (load) begin
        tx_word    <= gen_word ^ WIDTH'(inj_hit);
        tx_valid   <= 1'b1;
        tx_corrupt <= inj_hit;
        if (inject_period == 16'd0 || inj_hit) inj_cnt <= '0;
        else                                   inj_cnt <= inj_cnt + 16'd1;
        case (mode_e'(mode))
          MODE_PRBS: lfsr       <= lfsr_nxt;
          MODE_INCR: count_word <= count_word + 1'b1;
          MODE_ALT:  alt_phase  <= ~alt_phase;
          default:   ;
        endcase
      end else if (xfer) begin
        tx_valid <= 1'b0;
      end
      ref_valid <= 1'b0;
      if (rx_valid) begin
        if (fifo_count != '0) begin
          ref_word  <= fifo_head;
          ref_valid <= 1'b1;
        end else begin
          underflow <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ber_pattern_gen.sv
`timescale 1ns/1ps
module tb_ber_pattern_gen;
  localparam int          W        = 12;
  localparam int          DEPTH    = 16;
  localparam int          PRBS_LEN = 32767;
  localparam logic [14:0] SEED     = 15'h7FFF;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [1:0]    mode;
  logic [W-1:0]  fixed_word;
  logic [15:0]   inject_period;
  logic [W-1:0]  tx_word;
  logic          tx_valid;
  logic          tx_ready;
  logic          rx_valid;
  logic [W-1:0]  ref_word;
  logic          ref_valid;
  logic [31:0]   words_sent;
  logic [31:0]   injected;
  logic          underflow;

  always #5 clock = ~clock;

  ber_pattern_gen #(.WIDTH(W), .SEED(SEED), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode),
    .fixed_word(fixed_word), .inject_period(inject_period),
    .tx_word(tx_word), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .ref_word(ref_word), .ref_valid(ref_valid),
    .words_sent(words_sent), .injected(injected), .underflow(underflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: PRBS bit sequence over one full period, plus generator and FIFO state.
  bit           prbs_seq [PRBS_LEN];
  int           m_prbs_pos, m_cnt, m_k, m_sent, m_inj;
  bit           m_alt, m_uf;
  logic [W-1:0] m_ref;
  logic [W-1:0] m_fifo [$];

  bit           s_xfer, s_held, s_rx, s_ref_exp;
  logic [W-1:0] s_word, s_exp_word;

  task automatic build_prbs();
    bit hist [PRBS_LEN + 15];
    logic [14:0] sd;
    sd = SEED;
    for (int j = 0; j < 15; j++) hist[j] = sd[14 - j];
    for (int j = 15; j < PRBS_LEN + 15; j++) hist[j] = hist[j - 15] ^ hist[j - 14];
    for (int n = 0; n < PRBS_LEN; n++) prbs_seq[n] = hist[n + 15];
  endtask

  task automatic model_reset();
    m_prbs_pos = 0; m_cnt = 0; m_k = 0; m_sent = 0; m_inj = 0;
    m_alt = 0; m_uf = 0; m_ref = '0;
    m_fifo.delete();
  endtask

  task automatic model_next(input logic [1:0] md, output logic [W-1:0] w);
    w = '0;
    case (md)
      2'b00: begin
        for (int b = 0; b < W; b++) w[W-1-b] = prbs_seq[(m_prbs_pos + b) % PRBS_LEN];
        m_prbs_pos = (m_prbs_pos + W) % PRBS_LEN;
      end
      2'b01: begin
        w = W'(m_cnt);
        m_cnt = (m_cnt + 1) % (1 << W);
      end
      2'b10: w = fixed_word;
      default: begin
        for (int b = 0; b < W; b++) w[b] = ((b % 2) == 0) ? !m_alt : m_alt;
        m_alt = !m_alt;
      end
    endcase
  endtask

  // Advance one clock, updating the model from what was presented before the edge.
  task automatic step();
    logic [W-1:0] clean;
    bit corrupt;
    s_xfer = tx_valid && tx_ready;
    s_held = tx_valid && !tx_ready;
    s_word = tx_word;
    s_rx = rx_valid;
    s_ref_exp = 0;
    if (s_rx) begin
      if (m_fifo.size() > 0) begin
        s_ref_exp = 1;
        m_ref = m_fifo.pop_front();
      end else begin
        m_uf = 1;
      end
    end
    if (s_xfer) begin
      model_next(mode, clean);
      m_k++;
      corrupt = (inject_period != 0) && ((m_k % inject_period) == 0);
      s_exp_word = clean ^ W'(corrupt);
      m_fifo.push_back(clean);
      m_sent++;
      if (corrupt) m_inj++;
    end
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1; enable = 0; tx_ready = 0; rx_valid = 0;
    #3;
    model_reset();
    @(posedge clock); #1;
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({tx_word, tx_valid, ref_word, ref_valid, words_sent, injected, underflow} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {tx_word, tx_valid, ref_word, ref_valid, words_sent, injected, underflow});
    end
  endtask

  task automatic test_prbs();
    logic [W-1:0] wlast;
    wlast = 'x;
    do_reset();
    mode = 2'b00; inject_period = 0; enable = 1; tx_ready = 1;
    step();
    n_cmp++;
    if (tx_valid !== 1'b1 || tx_word !== 12'h000) begin
      n_bad++; $display("FAIL prbs_first_word: got v=%b %h want v=1 000", tx_valid, tx_word);
    end
    for (int c = 0; c < 33000 && m_sent < 32768; c++) begin
      rx_valid = (m_fifo.size() > 0);
      step();
      if (s_xfer) begin
        if (m_sent == 32768) wlast = s_word;
        n_cmp++;
        if (s_word !== s_exp_word) begin
          n_bad++; $display("FAIL prbs_word[%0d]: got %h want %h", m_sent - 1, s_word, s_exp_word);
        end
      end
      if (s_ref_exp) begin
        n_cmp++;
        if (ref_valid !== 1'b1 || ref_word !== m_ref) begin
          n_bad++; $display("FAIL prbs_ref: got v=%b %h want v=1 %h", ref_valid, ref_word, m_ref);
        end
      end
    end
    rx_valid = 0;
    n_cmp++;
    if (wlast !== 12'h000) begin
      n_bad++; $display("FAIL prbs_word32767: got %h want 000", wlast);
    end
    n_cmp++;
    if (words_sent !== 32'd32768) begin
      n_bad++; $display("FAIL prbs_words_sent: got %0d want 32768", words_sent);
    end
  endtask

  task automatic test_incr();
    do_reset();
    mode = 2'b01; inject_period = 0; enable = 1; tx_ready = 1;
    for (int c = 0; c < 4100; c++) begin
      rx_valid = (m_fifo.size() > 0);
      step();
      if (s_xfer) begin
        n_cmp++;
        if (s_word !== s_exp_word) begin
          n_bad++; $display("FAIL incr_word[%0d]: got %h want %h", m_sent - 1, s_word, s_exp_word);
        end
        if (m_sent == 4097 || m_sent == 4098) begin
          n_cmp++;
          if (s_word !== W'(m_sent - 4097)) begin
            n_bad++; $display("FAIL incr_wrap: got %h want %h", s_word, W'(m_sent - 4097));
          end
        end
      end
    end
    rx_valid = 0;
    n_cmp++;
    if (words_sent !== 32'(m_sent) || m_sent < 4097) begin
      n_bad++; $display("FAIL incr_words_sent: got %0d want %0d (>=4097)", words_sent, m_sent);
    end
  endtask

  task automatic test_alt_toggle();
    do_reset();
    mode = 2'b11; inject_period = 0; enable = 1;
    for (int c = 0; c < 40; c++) begin
      tx_ready = c[0];
      rx_valid = (m_fifo.size() > 0);
      step();
      if (s_held) begin
        n_cmp++;
        if (tx_valid !== 1'b1 || tx_word !== s_word) begin
          n_bad++; $display("FAIL alt_hold: got v=%b %h want v=1 %h", tx_valid, tx_word, s_word);
        end
      end
      if (s_xfer) begin
        n_cmp++;
        if (s_word !== s_exp_word || (m_sent == 1 && s_word !== 12'h555) ||
            (m_sent == 2 && s_word !== 12'hAAA)) begin
          n_bad++; $display("FAIL alt_word[%0d]: got %h want %h", m_sent - 1, s_word, s_exp_word);
        end
      end
    end
    tx_ready = 0; rx_valid = 0;
    n_cmp++;
    if (words_sent !== 32'(m_sent) || m_sent < 15) begin
      n_bad++; $display("FAIL alt_words_sent: got %0d want %0d (>=15)", words_sent, m_sent);
    end
  endtask

  task automatic test_inject();
    logic [W-1:0] want;
    do_reset();
    mode = 2'b10; fixed_word = 12'h0F0; inject_period = 16'd3; enable = 1;
    for (int c = 0; c < 14; c++) begin
      tx_ready = (m_sent < 9);
      step();
      if (s_xfer) begin
        want = ((m_sent % 3) == 0) ? 12'h0F1 : 12'h0F0;
        n_cmp++;
        if (s_word !== want) begin
          n_bad++; $display("FAIL inject_word[%0d]: got %h want %h", m_sent - 1, s_word, want);
        end
      end
    end
    enable = 0; tx_ready = 0;
    n_cmp++;
    if (injected !== 32'd3 || words_sent !== 32'd9) begin
      n_bad++; $display("FAIL inject_counts: got inj=%0d sent=%0d want 3 9", injected, words_sent);
    end
    for (int p = 0; p < 3; p++) begin
      rx_valid = 1;
      step();
      rx_valid = 0;
      n_cmp++;
      if (ref_valid !== 1'b1 || ref_word !== 12'h0F0) begin
        n_bad++; $display("FAIL inject_ref[%0d]: got v=%b %h want v=1 0f0", p, ref_valid, ref_word);
      end
      step();
      n_cmp++;
      if (ref_valid !== 1'b0) begin
        n_bad++; $display("FAIL inject_ref_pulse[%0d]: got v=%b want 0", p, ref_valid);
      end
    end
  endtask

  task automatic test_fill();
    do_reset();
    mode = 2'b01; inject_period = 0; enable = 1; tx_ready = 1;
    for (int c = 0; c < 30; c++) step();
    n_cmp++;
    if (words_sent !== 32'd16 || tx_valid !== 1'b0) begin
      n_bad++; $display("FAIL fill_stop: got sent=%0d v=%b want 16 0", words_sent, tx_valid);
    end
    rx_valid = 1;
    step();
    rx_valid = 0;
    for (int c = 0; c < 20; c++) step();
    n_cmp++;
    if (words_sent !== 32'd17 || tx_valid !== 1'b0) begin
      n_bad++; $display("FAIL fill_one_more: got sent=%0d v=%b want 17 0", words_sent, tx_valid);
    end
    enable = 0;
    for (int p = 0; p < 16; p++) begin
      rx_valid = 1;
      step();
      n_cmp++;
      if (ref_valid !== 1'b1 || ref_word !== W'(p + 1)) begin
        n_bad++; $display("FAIL fill_drain[%0d]: got v=%b %h want v=1 %h", p, ref_valid, ref_word, W'(p + 1));
      end
    end
    step();
    rx_valid = 0;
    n_cmp++;
    if (underflow !== 1'b1 || ref_valid !== 1'b0 || ref_word !== 12'd16) begin
      n_bad++; $display("FAIL underflow_set: got uf=%b v=%b %h want 1 0 010", underflow, ref_valid, ref_word);
    end
    for (int c = 0; c < 5; c++) step();
    n_cmp++;
    if (underflow !== 1'b1) begin
      n_bad++; $display("FAIL underflow_sticky: got %b want 1", underflow);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    mode = 2'b00; inject_period = 0; enable = 1; tx_ready = 1;
    for (int c = 0; c < 20 && m_sent < 5; c++) step();
    n_cmp++;
    if (tx_valid !== 1'b1 || words_sent !== 32'd5) begin
      n_bad++; $display("FAIL mid_precondition: got v=%b sent=%0d want 1 5", tx_valid, words_sent);
    end
    #3 reset = 1;
    #1;
    n_cmp++;
    if ({tx_word, tx_valid, ref_word, ref_valid, words_sent, injected, underflow} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got %h want 0",
               {tx_word, tx_valid, ref_word, ref_valid, words_sent, injected, underflow});
    end
    @(posedge clock); #1;
    model_reset();
    reset = 0;
    step();
    n_cmp++;
    if (tx_valid !== 1'b1 || tx_word !== 12'h000) begin
      n_bad++; $display("FAIL mid_restart_word: got v=%b %h want v=1 000", tx_valid, tx_word);
    end
    for (int c = 0; c < 8; c++) begin
      rx_valid = (m_fifo.size() > 0);
      step();
      if (s_ref_exp) begin
        n_cmp++;
        if (ref_valid !== 1'b1 || ref_word !== m_ref) begin
          n_bad++; $display("FAIL mid_restart_ref: got v=%b %h want v=1 %h", ref_valid, ref_word, m_ref);
        end
      end
    end
    rx_valid = 0;
  endtask

  task automatic test_random(input int cycles);
    do_reset();
    mode = 2'($urandom_range(3)); inject_period = 16'($urandom_range(4));
    fixed_word = W'($urandom);
    for (int c = 0; c < cycles; c++) begin
      if (!tx_valid && ($urandom_range(15) == 0)) mode = 2'($urandom_range(3));
      enable   = ($urandom_range(3) != 0);
      tx_ready = ($urandom_range(2) != 0);
      rx_valid = ($urandom_range(2) == 0);
      step();
      if (s_held) begin
        n_cmp++;
        if (tx_valid !== 1'b1 || tx_word !== s_word) begin
          n_bad++; $display("FAIL rnd_hold: got v=%b %h want v=1 %h", tx_valid, tx_word, s_word);
        end
      end
      if (s_xfer) begin
        n_cmp++;
        if (s_word !== s_exp_word) begin
          n_bad++; $display("FAIL rnd_word[%0d]: got %h want %h", m_sent - 1, s_word, s_exp_word);
        end
      end
      n_cmp++;
      if (ref_valid !== s_ref_exp || ref_word !== m_ref || underflow !== m_uf ||
          words_sent !== 32'(m_sent) || injected !== 32'(m_inj)) begin
        n_bad++;
        $display("FAIL rnd_state: got v=%b ref=%h uf=%b sent=%0d inj=%0d want v=%b ref=%h uf=%b sent=%0d inj=%0d",
                 ref_valid, ref_word, underflow, words_sent, injected,
                 s_ref_exp, m_ref, m_uf, m_sent, m_inj);
      end
    end
    rx_valid = 0; enable = 0; tx_ready = 0;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; enable = 0; mode = 0; fixed_word = '0; inject_period = 0;
    tx_ready = 0; rx_valid = 0;
    build_prbs();
    test_reset();
    test_prbs();
    test_incr();
    test_alt_toggle();
    test_inject();
    test_fill();
    test_reset_mid();
    for (int r = 0; r < 3; r++) test_random(1000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ber_pattern_gen.md
# ber_pattern_gen

Transmit-side companion of the bit-error-rate checkers. Generates the known test word stream (PRBS-15, counter, fixed or alternating) toward the channel over a valid/ready handshake, optionally corrupting selected words. Buffers every clean transmitted word in a reference FIFO and releases it, aligned with each received word, as the expected pattern and enable for the BER checker.

## Interface
- WIDTH, 12: word width; 12 for audio words, 8 for text words.
- SEED, 15'h7FFF: PRBS-15 reset state; value 0 is replaced by 15'h0001 (lockup guard).
- FIFO_DEPTH, 16: reference FIFO entries; power of two, ≥2.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  allows new words to be generated.
- mode  in  2  00 PRBS-15, 01 incrementing, 10 fixed_word, 11 alternating.
- fixed_word  in  WIDTH  pattern for mode 10.
- inject_period  in  16  0 = no injection; N = every Nth loaded word corrupted.
- tx_word  out  WIDTH  word to channel.
- tx_valid  out  1  tx_word valid.
- tx_ready  in  1  channel accepts tx_word.
- rx_valid  in  1  one-cycle pulse per word from receiver; pops reference.
- ref_word  out  WIDTH  expected word (checker pattern1).
- ref_valid  out  1  one-cycle pulse; drives checker enable.
- words_sent  out  32  accepted transfers, wraps.
- injected  out  32  accepted corrupted transfers, wraps.
- underflow  out  1  sticky: rx_valid with empty FIFO.

## Operation
- Transfer = tx_valid && tx_ready on a rising edge.
- Load: when enable && FIFO not full && (!tx_valid || transfer), next word registered into tx_word, tx_valid=1. Otherwise, on transfer tx_valid drops to 0; else tx_word/tx_valid held.
- Held word never changes while tx_valid && !tx_ready, regardless of enable or mode.
- enable low: no new loads; presented word stays until accepted.
- PRBS-15 (x^15+x^14+1): per bit fb = lfsr[14]^lfsr[13], lfsr <= {lfsr[13:0],fb}; WIDTH bits per load, first bit is tx_word MSB. LFSR advances only on load and keeps state across mode changes.
- Incrementing: 0,1,2,…, wraps at 2^WIDTH−1 to 0; advances only on load.
- Alternating: 0101…01 then 1010…10 in turn, starting with 0101…01 after reset.
- Mode change takes effect on the next load.
- Injection: inj_cnt counts loads while inject_period≠0. The load with inj_cnt == inject_period−1 gets tx_word[0] inverted and resets inj_cnt to 0; a flag marks the word corrupted. inject_period=1 corrupts every word. inject_period=0 holds inj_cnt at 0.
- On transfer: clean (uncorrupted) word pushed to FIFO; words_sent+1; injected+1 if flag set.
- On rx_valid: if FIFO non-empty, pop the oldest entry to ref_word with ref_valid=1 next cycle. If empty, set underflow; ref_valid stays 0 and ref_word holds.
- Pop sees only entries pushed on earlier edges. Push and pop on the same edge with the FIFO empty gives underflow. With the FIFO non-empty, both occur and occupancy is unchanged.
- FIFO full blocks loads, so overflow cannot occur.

## Timing
- Reset values: tx_word 0, tx_valid 0, ref_word 0, ref_valid 0, words_sent 0, injected 0, underflow 0, lfsr SEED, counter 0, alternate phase 0, inj_cnt 0, FIFO empty.
- Load latency: enable sampled high at edge k gives tx_valid=1 after edge k. Back-to-back transfers are sustained, one per cycle, while tx_ready=1 and the FIFO is not full.
- Reference latency: rx_valid at edge k gives ref_word/ref_valid after edge k, for one cycle only.
- Reset mid-transfer: all outputs return to reset values immediately. The FIFO content is discarded and PRBS restarts from SEED.

## Test plan
- WIDTH=12, SEED default, mode 00, tx_ready=1 -> first tx_word 12'h000. Word 32767 equals word 0. words_sent=32768 after 32768 transfers.
- mode 01, tx_ready=1 for 4100 cycles -> words 0…4095, then 0, 1, … (wrap).
- mode 11, tx_ready toggling every cycle -> 12'h555 held until accepted, then 12'hAAA. No word skipped or repeated.
- inject_period=3, mode 10, fixed_word=12'h0F0, 9 transfers -> tx_word 0F0,0F0,0F1 repeating; injected=3. Three rx_valid pulses -> each ref_word 0F0, ref_valid pulses 1 cycle later.
- tx_ready=1, no rx_valid -> 16 transfers then tx_valid=0. A single rx_valid pulse -> exactly one more transfer. rx_valid with FIFO empty -> underflow=1 and stays set until reset.
- Assert reset while tx_valid=1 and FIFO holds 5 entries -> all outputs 0 immediately. After release with mode 00, first word is again 12'h000.
